// File: rtl/cvxif_copro_alu.sv
// rtl/cvxif_copro_alu.sv - CV-X-IF coprocessor ALU (CADD/CSUB/CMUL) with in-order commit-gated results
//
// Responds to the core's CV-X-IF offload port. Three custom-0 instructions are
// decoded combinationally and accepted or rejected in the issue cycle. Accepted
// instructions are held in an in-order buffer, executed one at a time from the
// head (CMUL through an XLEN-step shift-add multiplier), and returned only
// once the core has committed them. Killed instructions leave without a result.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_i               drop every buffered entry and abort execution
//   x_issue_*             issue channel: instr/operands/id in, ready/accept/writeback out
//   x_commit_*            commit (kill=0) or kill (kill=1) message for an id
//   x_result_*            result channel: id/data/rd/we out, ready in

module cvxif_copro_alu #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned QUEUE_DEPTH   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     x_issue_valid_i,
  output logic                     x_issue_ready_o,
  input  logic [31:0]              x_issue_instr_i,
  input  logic [XLEN-1:0]          x_issue_rs1_i,
  input  logic [XLEN-1:0]          x_issue_rs2_i,
  input  logic [TRANS_ID_BITS-1:0] x_issue_id_i,
  output logic                     x_issue_accept_o,
  output logic                     x_issue_writeback_o,
  input  logic                     x_commit_valid_i,
  input  logic [TRANS_ID_BITS-1:0] x_commit_id_i,
  input  logic                     x_commit_kill_i,
  output logic                     x_result_valid_o,
  input  logic                     x_result_ready_i,
  output logic [TRANS_ID_BITS-1:0] x_result_id_o,
  output logic [XLEN-1:0]          x_result_data_o,
  output logic [4:0]               x_result_rd_o,
  output logic                     x_result_we_o
);

  localparam int unsigned IDX_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned EXT_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned STEP_W = $clog2(XLEN);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(QUEUE_DEPTH - 1);
  localparam logic [EXT_W-1:0]  DEPTH_EXT = EXT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(QUEUE_DEPTH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(XLEN - 1);

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  // Buffer payload (no reset needed: only slots below count are ever read)
  logic [TRANS_ID_BITS-1:0] q_id  [QUEUE_DEPTH];
  logic [1:0]               q_op  [QUEUE_DEPTH];
  logic [4:0]               q_rd  [QUEUE_DEPTH];
  logic [XLEN-1:0]          q_rs1 [QUEUE_DEPTH];
  logic [XLEN-1:0]          q_rs2 [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]   q_committed;
  logic [QUEUE_DEPTH-1:0]   q_killed;

  logic [IDX_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  state_t            state;
  logic [XLEN-1:0]   mcand, mplier, acc, res;
  logic [STEP_W-1:0] step;

  logic              decode_ok, push, pop, res_fire;
  logic              head_valid, head_killed, head_committed;
  logic              cm_hit, cm_new;
  logic [IDX_W-1:0]  cm_idx;
  logic [EXT_W-1:0]  slot;
  logic [XLEN-1:0]   acc_next;
  logic              unused_instr;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign unused_instr = ^x_issue_instr_i[24:15];

  assign decode_ok = (x_issue_instr_i[6:0] == OPC_CUSTOM0) &&
                     (x_issue_instr_i[31:25] == 7'd0) &&
                     (x_issue_instr_i[14:12] == 3'b000 ||
                      x_issue_instr_i[14:12] == 3'b001 ||
                      x_issue_instr_i[14:12] == 3'b010);

  assign x_issue_accept_o    = decode_ok;
  assign x_issue_writeback_o = decode_ok;
  assign x_issue_ready_o     = (count != FULL_CNT);

  assign head_valid     = (count != '0);
  assign head_killed    = head_valid && q_killed[rd_ptr];
  assign head_committed = head_valid && q_committed[rd_ptr];

  assign push = !flush_i && x_issue_valid_i && x_issue_ready_o && decode_ok;

  assign x_result_valid_o = !flush_i && (state == S_DONE) && head_committed && !head_killed;
  assign res_fire         = x_result_valid_o && x_result_ready_i;
  assign pop              = !flush_i && (head_killed || res_fire);

  assign x_result_id_o   = x_result_valid_o ? q_id[rd_ptr] : '0;
  assign x_result_rd_o   = x_result_valid_o ? q_rd[rd_ptr] : '0;
  assign x_result_data_o = x_result_valid_o ? res : '0;
  assign x_result_we_o   = x_result_valid_o;

  // Oldest undecided buffered entry with a matching id, walking from the head
  always_comb begin
    cm_hit = 1'b0;
    cm_idx = '0;
    slot   = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      slot = {1'b0, rd_ptr} + EXT_W'(i);
      if (slot >= DEPTH_EXT) slot = slot - DEPTH_EXT;
      if (x_commit_valid_i && !cm_hit && (CNT_W'(i) < count) &&
          (q_id[slot[IDX_W-1:0]] == x_commit_id_i) &&
          !q_committed[slot[IDX_W-1:0]] && !q_killed[slot[IDX_W-1:0]]) begin
        cm_hit = 1'b1;
        cm_idx = slot[IDX_W-1:0];
      end
    end
  end

  // A commit that finds no buffered match may target the entry issued this cycle
  assign cm_new = push && x_commit_valid_i && !cm_hit && (x_commit_id_i == x_issue_id_i);

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_id[wr_ptr]  <= x_issue_id_i;
      q_op[wr_ptr]  <= x_issue_instr_i[13:12];
      q_rd[wr_ptr]  <= x_issue_instr_i[11:7];
      q_rs1[wr_ptr] <= x_issue_rs1_i;
      q_rs2[wr_ptr] <= x_issue_rs2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      q_committed <= '0;
      q_killed    <= '0;
      state       <= S_IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      res         <= '0;
      step        <= '0;
    end else if (flush_i) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      q_committed <= '0;
      q_killed    <= '0;
      state       <= S_IDLE;
    end else begin
      if (cm_hit) begin
        if (x_commit_kill_i) q_killed[cm_idx]    <= 1'b1;
        else                 q_committed[cm_idx] <= 1'b1;
      end
      if (push) begin
        q_committed[wr_ptr] <= cm_new && !x_commit_kill_i;
        q_killed[wr_ptr]    <= cm_new && x_commit_kill_i;
        wr_ptr              <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A killed head abandons whatever is in flight for it
      if (head_killed) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (head_valid) begin
              case (q_op[rd_ptr])
                2'b00: begin
                  res   <= q_rs1[rd_ptr] + q_rs2[rd_ptr];
                  state <= S_DONE;
                end
                2'b01: begin
                  res   <= q_rs1[rd_ptr] - q_rs2[rd_ptr];
                  state <= S_DONE;
                end
                default: begin
                  mcand  <= q_rs1[rd_ptr];
                  mplier <= q_rs2[rd_ptr];
                  acc    <= '0;
                  step   <= '0;
                  state  <= S_MUL;
                end
              endcase
            end
          end
          S_MUL: begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + 1'b1;
            if (step == LAST_STEP) begin
              res   <= acc_next;
              state <= S_DONE;
            end
          end
          S_DONE: begin
            if (res_fire) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cvxif_copro_alu.sv
// tb/tb_cvxif_copro_alu.sv - self-checking bench for cvxif_copro_alu

module tb_cvxif_copro_alu;

  localparam logic [6:0] OPC = 7'b0001011;

  logic        clk, rst_n, flush;
  logic        iv, ir, acc, wb;
  logic [31:0] instr, rs1, rs2;
  logic [2:0]  iid, cid, rid;
  logic        cv, ck;
  logic        rv, rr, rwe;
  logic [31:0] rdata;
  logic [4:0]  rrd;

  int checks;
  int failures;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          committed;
    bit          killed;
  } ent_t;

  cvxif_copro_alu #(.XLEN(32), .TRANS_ID_BITS(3), .QUEUE_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .x_issue_valid_i(iv), .x_issue_ready_o(ir), .x_issue_instr_i(instr),
    .x_issue_rs1_i(rs1), .x_issue_rs2_i(rs2), .x_issue_id_i(iid),
    .x_issue_accept_o(acc), .x_issue_writeback_o(wb),
    .x_commit_valid_i(cv), .x_commit_id_i(cid), .x_commit_kill_i(ck),
    .x_result_valid_o(rv), .x_result_ready_i(rr), .x_result_id_o(rid),
    .x_result_data_o(rdata), .x_result_rd_o(rrd), .x_result_we_o(rwe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  function automatic bit ref_accept(input logic [31:0] ins);
    return (ins[6:0] == OPC) && (ins[31:25] == 7'd0) && (ins[14:12] <= 3'd2);
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      default: r = a * b;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ir); end
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rv); end
    checks++; if ({rid, rdata, rrd, rwe} !== 41'd0) begin failures++;
      $display("FAIL reset_result_fields got id=%0d data=%h rd=%0d we=%b exp all 0", rid, rdata, rrd, rwe); end
    checks++; if (acc !== 1'b0 || wb !== 1'b0) begin failures++;
      $display("FAIL reset_accept got acc=%b wb=%b exp 0/0", acc, wb); end
  endtask

  task automatic test_cadd();
    logic [31:0] exp;
    exp = ref_result(3'd0, 32'd5, 32'd7);
    tick();
    iv = 1; instr = mk_instr(7'd0, 3'd0, 5'd10, OPC); rs1 = 5; rs2 = 7; iid = 3; rr = 1;
    #1;
    checks++; if (acc !== 1'b1 || wb !== 1'b1) begin failures++;
      $display("FAIL cadd_accept got acc=%b wb=%b exp 1/1", acc, wb); end
    tick();
    iv = 0; cv = 1; cid = 3; ck = 0;
    #1;
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL cadd_early got=%b exp=0", rv); end
    tick();
    cv = 0;
    #1;
    checks++; if (rv !== 1'b1 || rid !== 3'd3 || rdata !== exp || rrd !== 5'd10 || rwe !== 1'b1) begin
      failures++;
      $display("FAIL cadd_result got v=%b id=%0d data=%h rd=%0d we=%b exp v=1 id=3 data=%h rd=10 we=1",
               rv, rid, rdata, rrd, rwe, exp);
    end
    tick();
    #1;
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL cadd_pop got=%b exp=0", rv); end
  endtask

  task automatic test_cmul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] id);
    logic [31:0] exp;
    bit early;
    exp = ref_result(3'd2, a, b);
    early = 0;
    tick();
    iv = 1; instr = mk_instr(7'd0, 3'd2, 5'd7, OPC); rs1 = a; rs2 = b; iid = id;
    cv = 1; cid = id; ck = 0; rr = 1;
    #1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      iv = 0; cv = 0;
      #1;
      if (rv) early = 1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL cmul_early got=1 exp=0"); end
    tick();
    #1;
    checks++; if (rv !== 1'b1 || rdata !== exp || rid !== id || rrd !== 5'd7) begin
      failures++;
      $display("FAIL cmul_result got v=%b id=%0d data=%h rd=%0d exp v=1 id=%0d data=%h rd=7",
               rv, rid, rdata, rrd, id, exp);
    end
    tick();
    #1;
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL cmul_pop got=%b exp=0", rv); end
  endtask

  task automatic test_reject();
    bit seen;
    seen = 0;
    tick();
    iv = 1; instr = mk_instr(7'd0, 3'd0, 5'd9, 7'h33); rs1 = 1; rs2 = 2; iid = 1;
    cv = 1; cid = 1; ck = 0; rr = 1;
    #1;
    checks++; if (acc !== 1'b0 || wb !== 1'b0 || ir !== 1'b1) begin failures++;
      $display("FAIL reject_op33 got acc=%b wb=%b ready=%b exp 0/0/1", acc, wb, ir); end
    tick();
    instr = mk_instr(7'd0, 3'd3, 5'd9, OPC); iid = 2; cid = 2;
    #1;
    checks++; if (acc !== 1'b0) begin failures++; $display("FAIL reject_funct3 got=%b exp=0", acc); end
    tick();
    instr = mk_instr(7'h01, 3'd0, 5'd9, OPC); iid = 3; cid = 3;
    #1;
    checks++; if (acc !== 1'b0) begin failures++; $display("FAIL reject_funct7 got=%b exp=0", acc); end
    tick();
    iv = 0; cv = 0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (rv) seen = 1;
      tick();
      #1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL reject_no_result got=1 exp=0"); end
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL reject_ready got=%b exp=1", ir); end
  endtask

  task automatic test_kill_stall();
    logic [31:0] a1, b1, a2, b2, exp2;
    bit unstable;
    bit seen;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    exp2 = ref_result(3'd1, a2, b2);
    unstable = 0;
    seen = 0;
    tick();
    iv = 1; instr = mk_instr(7'd0, 3'd0, 5'd3, OPC); rs1 = a1; rs2 = b1; iid = 1; rr = 0;
    #1;
    tick();
    instr = mk_instr(7'd0, 3'd1, 5'd4, OPC); rs1 = a2; rs2 = b2; iid = 2;
    #1;
    tick();
    iv = 0; cv = 1; cid = 1; ck = 1;
    #1;
    tick();
    cid = 2; ck = 0;
    #1;
    tick();
    cv = 0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (rv) break;
      tick();
      #1;
    end
    checks++; if (rv !== 1'b1 || rid !== 3'd2 || rdata !== exp2 || rrd !== 5'd4) begin
      failures++;
      $display("FAIL kill_result got v=%b id=%0d data=%h rd=%0d exp v=1 id=2 data=%h rd=4",
               rv, rid, rdata, rrd, exp2);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      if (rv !== 1'b1 || rid !== 3'd2 || rdata !== exp2) unstable = 1;
    end
    checks++; if (unstable !== 1'b0) begin failures++; $display("FAIL stall_stable got unstable=1 exp=0"); end
    rr = 1;
    tick();
    #1;
    for (int c = 0; c < 10; c++) begin
      if (rv) seen = 1;
      tick();
      #1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill_no_extra got=1 exp=0"); end
  endtask

  task automatic test_full();
    bit seen;
    seen = 0;
    tick();
    iv = 1; instr = mk_instr(7'd0, 3'd0, 5'd1, OPC); rs1 = $urandom; rs2 = $urandom; iid = 4; rr = 1;
    #1;
    tick();
    iid = 5;
    #1;
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL full_ready_one got=%b exp=1", ir); end
    tick();
    iid = 6;
    #1;
    checks++; if (ir !== 1'b0) begin failures++; $display("FAIL full_ready_zero got=%b exp=0", ir); end
    tick();
    iv = 0; cv = 1; cid = 4; ck = 0;
    #1;
    tick();
    cv = 0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (rv) break;
      tick();
      #1;
    end
    checks++; if (rv !== 1'b1 || rid !== 3'd4) begin failures++;
      $display("FAIL full_first got v=%b id=%0d exp v=1 id=4", rv, rid); end
    tick();
    cv = 1; cid = 5;
    #1;
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL full_ready_back got=%b exp=1", ir); end
    tick();
    cv = 0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (rv) break;
      tick();
      #1;
    end
    checks++; if (rv !== 1'b1 || rid !== 3'd5) begin failures++;
      $display("FAIL full_second got v=%b id=%0d exp v=1 id=5", rv, rid); end
    tick();
    cv = 1; cid = 6;
    #1;
    for (int c = 0; c < 20; c++) begin
      tick();
      cv = 0;
      #1;
      if (rv) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL full_dropped_issue got=1 exp=0"); end
  endtask

  task automatic test_flush();
    bit seen;
    logic [31:0] exp;
    seen = 0;
    exp = ref_result(3'd0, 32'hDEAD0000, 32'h0000BEEF);
    tick();
    iv = 1; instr = mk_instr(7'd0, 3'd2, 5'd2, OPC); rs1 = $urandom; rs2 = $urandom; iid = 1;
    cv = 1; cid = 1; ck = 0; rr = 1;
    #1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      iv = 0; cv = 0;
      flush = (c == 10);
      #1;
      if (rv) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_result got=1 exp=0"); end
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", ir); end
    tick();
    iv = 1; instr = mk_instr(7'd0, 3'd0, 5'd8, OPC); rs1 = 32'hDEAD0000; rs2 = 32'h0000BEEF; iid = 2;
    cv = 1; cid = 2;
    #1;
    tick();
    iv = 0; cv = 0;
    #1;
    checks++; if (rv !== 1'b0) begin failures++; $display("FAIL flush_next_early got=%b exp=0", rv); end
    tick();
    #1;
    checks++; if (rv !== 1'b1 || rid !== 3'd2 || rdata !== exp) begin failures++;
      $display("FAIL flush_next_result got v=%b id=%0d data=%h exp v=1 id=2 data=%h", rv, rid, rdata, exp); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    seen = 0;
    tick();
    iv = 1; instr = mk_instr(7'd0, 3'd2, 5'd5, OPC); rs1 = $urandom; rs2 = $urandom; iid = 3;
    cv = 1; cid = 3; ck = 0; rr = 1;
    #1;
    for (int c = 0; c < 6; c++) begin
      tick();
      iv = 0; cv = 0;
    end
    rst_n = 0;
    #1;
    checks++; if (rv !== 1'b0 || ir !== 1'b1) begin failures++;
      $display("FAIL rst_mid_mul_async got v=%b ready=%b exp 0/1", rv, ir); end
    tick();
    rst_n = 1;
    #1;
    for (int c = 0; c < 50; c++) begin
      if (rv) seen = 1;
      tick();
      #1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_mul_no_result got=1 exp=0"); end
  endtask

  task automatic test_random();
    ent_t        mq[$];
    ent_t        e;
    int          undec[$];
    int          issued;
    int          pick;
    int          first;
    bit          finished;
    bit          model_acc;
    logic [2:0]  f3;
    logic [4:0]  rdv;
    logic [31:0] a, b, ins;
    issued = 0;
    finished = 0;
    a = 0; b = 0; f3 = 0; rdv = 0; ins = 0;
    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      tick();
      iv = 0; cv = 0;
      if (issued < 60 && $urandom_range(0, 1) == 1) begin
        f3  = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 7) == 0) f3 = 3'd3;
        rdv = 5'($urandom);
        a   = $urandom;
        b   = $urandom;
        ins = mk_instr(7'd0, f3, rdv, OPC);
        if ($urandom_range(0, 9) == 0) ins = mk_instr(7'd0, f3, rdv, 7'h33);
        iv = 1; instr = ins; rs1 = a; rs2 = b; iid = 3'(issued);
      end
      undec.delete();
      foreach (mq[i]) if (!mq[i].committed && !mq[i].killed) undec.push_back(i);
      if (undec.size() > 0 && $urandom_range(0, 2) == 0) begin
        pick = undec[$urandom_range(0, undec.size() - 1)];
        cv = 1; cid = mq[pick].id; ck = ($urandom_range(0, 3) == 0);
      end
      rr = ($urandom_range(0, 3) != 0);
      #1;
      if (cv) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].id == cid && !mq[i].committed && !mq[i].killed) begin
            if (ck) mq[i].killed = 1;
            else    mq[i].committed = 1;
            break;
          end
        end
      end
      if (iv && ir) begin
        model_acc = ref_accept(ins);
        checks++; if (acc !== model_acc || wb !== model_acc) begin failures++;
          $display("FAIL rand_accept got acc=%b wb=%b exp=%b instr=%h", acc, wb, model_acc, ins); end
        if (model_acc) begin
          e.id = 3'(issued); e.data = ref_result(f3, a, b); e.rd = rdv;
          e.committed = 0; e.killed = 0;
          mq.push_back(e);
        end
        issued++;
      end
      if (rv && rr) begin
        first = -1;
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].killed) begin first = i; break; end
        end
        checks++;
        if (first < 0) begin
          failures++;
          $display("FAIL rand_unexpected got id=%0d data=%h exp no result", rid, rdata);
        end else begin
          if (!mq[first].committed || rid !== mq[first].id || rdata !== mq[first].data ||
              rrd !== mq[first].rd || rwe !== 1'b1) begin
            failures++;
            $display("FAIL rand_result got id=%0d data=%h rd=%0d exp id=%0d data=%h rd=%0d committed=%0d",
                     rid, rdata, rrd, mq[first].id, mq[first].data, mq[first].rd, mq[first].committed);
          end
          repeat (first + 1) void'(mq.pop_front());
        end
      end
      finished = (issued == 60);
      foreach (mq[i]) if (!mq[i].killed) finished = 0;
    end
    checks++; if (!finished) begin failures++;
      $display("FAIL rand_drain got issued=%0d pending=%0d exp all results delivered", issued, mq.size()); end
    iv = 0; cv = 0; rr = 1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 0; flush = 0; iv = 0; instr = 0; rs1 = 0; rs2 = 0; iid = 0;
    cv = 0; cid = 0; ck = 0; rr = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_cadd();
    test_cmul(32'hFFFFFFFF, 32'd3, 3'd5);
    test_cmul(32'h00010000, 32'h00010000, 3'd6);
    test_reject();
    test_kill_stall();
    test_full();
    test_flush();
    test_reset_mid_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
